reg_univ_n: RTL
===============

// Module: reg_univ_n
// PURPOSE
//  - Parametrised universal register: generalises the fixed 8-bit D register to WIDTH bits.
//  - Adds enable, parallel load, shift/rotate in both directions, clear and invert modes.
//  - Adds a shift counter with a one-cycle word_done pulse after WIDTH shifts.
//  - Used as a generic storage, serialiser or deserialiser element in datapaths.
// PARAMETERS
//  WIDTH    8    register width in bits; legal range WIDTH >= 2 (elaboration $error otherwise)
//  RST_VAL  '0   value loaded into q on reset (WIDTH bits)
// PORTS
//  clk        in   1                 clock; all state updates on the rising edge
//  rst        in   1                 synchronous reset, active-high
//  en         in   1                 operation enable; 0 = hold all state
//  mode       in   3 (reg_pkg::mode_t)  operation select, sampled when en=1
//  d          in   WIDTH             parallel load data
//  sin_l      in   1                 serial input entering at MSB (SHR)
//  sin_r      in   1                 serial input entering at LSB (SHL)
//  q          out  WIDTH             register contents
//  sout_l     out  1                 q[WIDTH-1], combinational from q
//  sout_r     out  1                 q[0], combinational from q
//  shift_cnt  out  $clog2(WIDTH)     shifts/rotates since last LOAD/CLR/reset, modulo WIDTH
//  word_done  out  1                 registered pulse: the WIDTH-th shift completed last edge
// BEHAVIOUR
//  - Reset: rst=1 at an edge gives q=RST_VAL, shift_cnt=0, word_done=0.
//  - Reset has priority over en and mode and aborts any shift sequence in progress.
//  - en=0: q and shift_cnt hold; word_done returns to 0.
//  - en=1, one-cycle latency; q updates on the edge per mode:
//      HOLD (0)  q unchanged
//      LOAD (1)  q<=d
//      SHL  (2)  q<={q[WIDTH-2:0],sin_r}
//      SHR  (3)  q<={sin_l,q[WIDTH-1:1]}
//      ROL  (4)  q<={q[WIDTH-2:0],q[WIDTH-1]}
//      ROR  (5)  q<={q[0],q[WIDTH-1:1]}
//      CLR  (6)  q<='0 (not RST_VAL)
//      INV  (7)  q<=~q
//  - shift_cnt:
//      LOAD or CLR: shift_cnt<=0.
//      SHL/SHR/ROL/ROR: shift_cnt increments.
//      At shift_cnt==WIDTH-1 a shift wraps shift_cnt to 0 and sets word_done<=1.
//      HOLD and INV leave shift_cnt unchanged.
//  - word_done is high exactly one cycle per WIDTH counted shifts; it is 0 in every other cycle.
//  - Mixed shift directions all count, so no direction tracking is done.
//  - With WIDTH not a power of two the counter still wraps at WIDTH-1, not at 2^n-1.
//  - Back-to-back LOAD followed immediately by a shift is legal; the shift acts on the loaded value.
//  - sout_l and sout_r reflect q before the edge, so the bit shifted out is visible before the shift.
//  - No X propagation from unused inputs: d, sin_l and sin_r are ignored in modes that do not use them.
// STRUCTURE
//  - Package reg_pkg:
//      typedef enum logic [2:0] mode_t {HOLD,LOAD,SHL,SHR,ROL,ROR,CLR,INV}
//      localparam MODE_W = 3
//  - Sub-module mod_counter #(MOD=WIDTH):
//      ports clk, rst, clr, inc, cnt, wrap
//      holds shift_cnt; wrap drives word_done.
//  - Top level: a single always_ff for q, the mode-decode case, and mod_counter instantiation.
// TESTING  (WIDTH=8, RST_VAL=0, clock period 10 ns, stimulus applied away from the edge)
//  1. rst=1, d=8'b00111011 for 2 edges -> q=00000000, shift_cnt=0, word_done=0.
//     Then rst=0, en=1, LOAD -> q=00111011 after one edge.
//  2. LOAD 10101010, then en=0 for 3 edges with mode=SHL -> q stays 10101010, shift_cnt=0.
//  3. LOAD 11110000, then SHL x8 with sin_r=1 -> q=11111111.
//     word_done=1 only in the cycle after the 8th shift; shift_cnt=0.
//  4. LOAD 10000001, then ROL -> q=00000011; ROR x2 -> q=11000000; shift_cnt=3.
//     Then INV -> q=00111111, shift_cnt still 3.
//  5. LOAD 00000000, then SHR x5 with sin_l=1 -> q=11111000, shift_cnt=5.
//     Then rst=1 mid-sequence -> q=0, shift_cnt=0, and no word_done pulse.
//  6. Serialise 8'b01101001 via SHR, capturing sout_r before each edge -> LSB-first bits 1,0,0,1,0,1,1,0.
//     Then CLR -> q=0, shift_cnt=0.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared types for the universal register: operation modes and a small decode helper.
package reg_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      HOLD = 3'd0,
      LOAD = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      ROL  = 3'd4,
      ROR  = 3'd5,
      CLR  = 3'd6,
      INV  = 3'd7
   } mode_t;

   // Shifts and rotates in either direction all advance the word counter.
   function automatic logic is_shift(input mode_t m);
      return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR);
   endfunction

   function automatic logic is_restart(input mode_t m);
      return (m == LOAD) || (m == CLR);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD event counter with a registered one-cycle wrap pulse.
module mod_counter #(
   parameter int MOD = 8,
   parameter int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(MOD - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          wrap_reg;
   logic          wrap_next;

   // Wrap at MOD-1 explicitly so non-power-of-two moduli do not run to 2^CW-1.
   always_comb begin
      cnt_next  = cnt_reg;
      wrap_next = 1'b0;
      if (clr) begin
         cnt_next = '0;
      end else if (inc) begin
         if (cnt_reg == LAST) begin
            cnt_next  = '0;
            wrap_next = 1'b1;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg  <= '0;
         wrap_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         wrap_reg <= wrap_next;
      end
   end

   assign cnt  = cnt_reg;
   assign wrap = wrap_reg;

endmodule

// File: rtl/reg_univ_n.sv
// WIDTH-bit universal register: load, shift/rotate both ways, clear, invert,
// with a shift counter that pulses word_done after every WIDTH shifts.
module reg_univ_n
   import reg_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  mode_t                    mode,
   input  logic [WIDTH-1:0]         d,
   input  logic                     sin_l,
   input  logic                     sin_r,
   output logic [WIDTH-1:0]         q,
   output logic                     sout_l,
   output logic                     sout_r,
   output logic [$clog2(WIDTH)-1:0] shift_cnt,
   output logic                     word_done
);

   localparam int CW = $clog2(WIDTH);

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("reg_univ_n: WIDTH must be >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] shl_v;
   logic [WIDTH-1:0] shr_v;
   logic [WIDTH-1:0] rol_v;
   logic [WIDTH-1:0] ror_v;

   // Per-bit neighbour selection; the edge bits take the serial input or the wrapped bit.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign shl_v[gi] = sin_r;
            assign rol_v[gi] = q_reg[WIDTH-1];
         end else begin : g_up
            assign shl_v[gi] = q_reg[gi-1];
            assign rol_v[gi] = q_reg[gi-1];
         end
         if (gi == WIDTH-1) begin : g_msb
            assign shr_v[gi] = sin_l;
            assign ror_v[gi] = q_reg[0];
         end else begin : g_dn
            assign shr_v[gi] = q_reg[gi+1];
            assign ror_v[gi] = q_reg[gi+1];
         end
      end
   endgenerate

   always_comb begin
      q_next = q_reg;
      if (en) begin
         case (mode)
            HOLD:    q_next = q_reg;
            LOAD:    q_next = d;
            SHL:     q_next = shl_v;
            SHR:     q_next = shr_v;
            ROL:     q_next = rol_v;
            ROR:     q_next = ror_v;
            CLR:     q_next = '0;
            INV:     q_next = ~q_reg;
            default: q_next = q_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg <= RST_VAL;
      end else begin
         q_reg <= q_next;
      end
   end

   logic cnt_clr;
   logic cnt_inc;

   assign cnt_clr = en && is_restart(mode);
   assign cnt_inc = en && is_shift(mode);

   mod_counter #(
      .MOD (WIDTH),
      .CW  (CW)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .cnt  (shift_cnt),
      .wrap (word_done)
   );

   assign q      = q_reg;
   assign sout_l = q_reg[WIDTH-1];
   assign sout_r = q_reg[0];

endmodule
